// File: rtl/ram8_sweep.sv
// 8-word register file with a demultiplexed write strobe, a combinational read mux,
// and a sequential clear sweeper that zeroes one word per cycle.
module ram8_sweep #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic [2:0]       address,
  input  logic             load,
  input  logic             clear_req,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             clear_done,
  output logic             write_drop
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SWEEP = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]       state_reg, state_next;
  logic [2:0]       ptr_reg, ptr_next;
  logic             busy_reg, done_reg, drop_reg;
  logic             accept;
  logic [7:0]       we;
  logic [7:0]       sweep_clr;
  logic [WIDTH-1:0] words [8];

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (clear_req) begin
          state_next = ST_SWEEP;
          ptr_next   = 3'd0;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_SWEEP: begin
        ptr_next = ptr_reg + 3'd1;
        if (ptr_reg == 3'd7) state_next = ST_DONE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Loads are only honoured outside the sweep, so the two write sources never collide.
  assign accept = (state_reg != ST_SWEEP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= 3'd0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      drop_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      busy_reg  <= (state_next == ST_SWEEP);
      done_reg  <= (state_next == ST_DONE);
      drop_reg  <= load && !accept;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_word
      logic [WIDTH-1:0] word_reg;

      assign we[gi]        = load && accept && (address == 3'(gi));
      assign sweep_clr[gi] = (state_reg == ST_SWEEP) && (ptr_reg == 3'(gi));
      assign words[gi]     = word_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          word_reg <= '0;
        end else if (sweep_clr[gi]) begin
          word_reg <= '0;
        end else if (we[gi]) begin
          word_reg <= in;
        end
      end
    end
  endgenerate

  assign out        = words[address];
  assign busy       = busy_reg;
  assign clear_done = done_reg;
  assign write_drop = drop_reg;

endmodule

// File: doc/ram8_sweep.md
Name: ram8_sweep

Overview:
- 8-word register file; the consumer of the 8-way demultiplexer stage.
- The 1-bit load strobe is demultiplexed by address into eight per-word write enables, one-hot or all zero.
- Each word is a WIDTH-bit register; the read path is an 8-way mux on address.
- Adds a sequential clear sweeper: on request, an FSM zeroes words 0..7 one per cycle, with busy/done signalling and write-drop reporting.

Parameters:
- WIDTH, 16, data word width in bits. Address width is fixed at 3 and depth is fixed at 8.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in  input  WIDTH  write data
- address  input  3  word select for read and write
- load  input  1  write strobe; sampled on a rising clk edge
- clear_req  input  1  request a full-array clear; level-sampled
- out  output  WIDTH  read data, combinational: out = mem[address]
- busy  output  1  high while the sweep is in progress
- clear_done  output  1  one-cycle pulse when the sweep completes
- write_drop  output  1  one-cycle pulse when a load was rejected

Behaviour:
- Reset (rst_n=0, asynchronous):
  - all 8 words = 0; state = IDLE; sweep pointer ptr = 0
  - busy = 0, clear_done = 0, write_drop = 0
  - out therefore reads 0 immediately.
  - Reset asserted mid-sweep aborts the sweep; there is no clear_done pulse.
- Write enable decode:
  - we[i] = load & (address == i) & ~busy_next_edge_blocked
  - In practice: a write occurs only in states IDLE or DONE. At most one we[i] is high.
- Write (IDLE or DONE, load=1): mem[address] <= in at the edge. New data is visible on out after that edge, same-cycle read returns old data.
- Read: purely combinational. No latency, no registering.
- FSM states: IDLE, SWEEP, DONE.
  - IDLE:
    - clear_req=1 -> SWEEP; ptr <= 0.
    - load in the same cycle is still performed; the sweep later zeroes it.
  - SWEEP:
    - each edge: mem[ptr] <= 0; ptr <= ptr + 1.
    - ptr==7 at the edge -> DONE; ptr wraps to 0.
    - clear_req ignored.
    - load=1 -> no write; write_drop = 1 for the following cycle.
  - DONE:
    - clear_done = 1 for exactly this one cycle.
    - behaves as IDLE for requests: load accepted; clear_req=1 -> SWEEP (back-to-back sweep).
    - otherwise -> IDLE.
- Timing: clear_req sampled high at edge k.
  - busy = 1 after edge k.
  - words 0..7 are zeroed at edges k+1..k+8.
  - busy = 0 and clear_done = 1 after edge k+8.
  - clear_done returns to 0 after edge k+9.
  - busy is high for exactly 8 cycles.
- busy is a registered output, high only in SWEEP. clear_done is registered, high only in DONE.
- write_drop is a registered one-cycle pulse per rejected load cycle. Consecutive rejected cycles give consecutive pulses.
- During SWEEP, out = mem[address] live: already-swept words read 0, unswept words keep their values.
- Data is never truncated or extended: WIDTH in, WIDTH stored, WIDTH out.

Test Plan:
- Reset then read all addresses:
  - release rst_n, sweep address 0..7 with load=0 -> out = 0 at every address.
- Write/read all words (WIDTH=16):
  - write mem[i] = 16'hA0A0 + i for i = 0..7 -> reading address i gives 16'hA0A0+i.
  - a same-cycle read during the write to address 3 shows the old value; the next cycle shows 16'hA0A3.
- Full sweep:
  - preload pattern, pulse clear_req 1 cycle -> busy high for exactly 8 cycles.
  - at cycle 4 of the sweep, address 2 reads 0 and address 6 still reads 16'hA0A6.
  - clear_done pulses once, then all 8 words read 0.
- Write during sweep:
  - load=1, address=5, in=16'h1234 in sweep cycle 2 -> write_drop pulses next cycle.
  - after clear_done, address 5 reads 0.
- Simultaneous and back-to-back:
  - in IDLE, load (address 7, 16'hBEEF) with clear_req -> address 7 reads 16'hBEEF, then 0 after the sweep.
  - clear_req held high through DONE -> a second sweep starts immediately; busy drops for only the single DONE cycle.
- Reset mid-sweep:
  - assert rst_n=0 asynchronously in sweep cycle 3 -> busy, clear_done and all words 0 immediately, with no clear_done pulse.
  - the FSM is IDLE on release.
